// File: rtl/ibex_pkg.sv
// Shared definitions for the iterative divider: op encoding and sequencer states.
package ibex_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ABS_A,
        ABS_B,
        DIV,
        FIX,
        DONE
    } div_state_e;

endpackage

// File: rtl/ibex_div_seq.sv
// Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU) that borrows the ALU's
// 33-bit adder for sign fix-up and every subtract step.
//
// state | meaning
// IDLE  | ready for a request
// ABS_A | dividend <= |a| for signed ops
// ABS_B | divisor  <= |b| for signed ops
// DIV   | 32 shift/subtract iterations, counter 31..0
// FIX   | sign-correct quotient or remainder into result_o
// DONE  | result_valid_o pulse
module ibex_div_seq
    import ibex_pkg::*;
#(
    parameter bit FAST_DIV0 = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        div_valid_i,
    output logic        div_ready_o,
    input  logic [1:0]  div_op_i,
    input  logic [31:0] div_a_i,
    input  logic [31:0] div_b_i,
    input  logic        kill_i,
    output logic        multdiv_en_o,
    output logic [32:0] multdiv_operand_a_o,
    output logic [32:0] multdiv_operand_b_o,
    input  logic [33:0] adder_result_ext_i,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    output logic        busy_o
);

    // With A={x,1} and B={~y,1} the adder yields x-y in [32:1] and x>=y in [33].
    function automatic logic [32:0] sub_a(input logic [31:0] x);
        return {x, 1'b1};
    endfunction

    function automatic logic [32:0] sub_b(input logic [31:0] y);
        return {~y, 1'b1};
    endfunction

    div_state_e  state_q, state_d;
    logic [1:0]  op_q;
    logic        sa_q, sb_q, b_zero_q;
    logic [31:0] dvd_q, divisor_q, rem_q;
    logic [4:0]  cnt_q;

    logic [31:0] adder_sum;
    logic        adder_carry;
    logic        unused_adder_lsb;
    logic [31:0] shifted;
    logic        take;
    logic [31:0] fix_val;
    logic        fix_neg;

    assign adder_sum        = adder_result_ext_i[32:1];
    assign adder_carry      = adder_result_ext_i[33];
    assign unused_adder_lsb = adder_result_ext_i[0];

    // rem[31] set means the true shifted remainder exceeds 2^32, so it always subtracts.
    assign shifted = {rem_q[30:0], dvd_q[31]};
    assign take    = rem_q[31] | adder_carry;
    assign fix_val = op_q[1] ? rem_q : dvd_q;
    assign fix_neg = op_q[1] ? sa_q : ((sa_q ^ sb_q) & ~b_zero_q);

    assign div_ready_o    = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign result_valid_o = (state_q == DONE);

    always_comb begin
        state_d             = state_q;
        multdiv_en_o        = 1'b0;
        multdiv_operand_a_o = '0;
        multdiv_operand_b_o = '0;
        case (state_q)
            IDLE: begin
                if (div_valid_i) state_d = ABS_A;
            end
            ABS_A: begin
                multdiv_en_o        = 1'b1;
                multdiv_operand_a_o = sub_a(32'h0);
                multdiv_operand_b_o = sub_b(dvd_q);
                state_d             = ABS_B;
            end
            ABS_B: begin
                multdiv_en_o        = 1'b1;
                multdiv_operand_a_o = sub_a(32'h0);
                multdiv_operand_b_o = sub_b(divisor_q);
                state_d             = (FAST_DIV0 && b_zero_q) ? FIX : DIV;
            end
            DIV: begin
                multdiv_en_o        = 1'b1;
                multdiv_operand_a_o = sub_a(shifted);
                multdiv_operand_b_o = sub_b(divisor_q);
                if (cnt_q == 5'd0) state_d = FIX;
            end
            FIX: begin
                multdiv_en_o        = 1'b1;
                multdiv_operand_a_o = sub_a(32'h0);
                multdiv_operand_b_o = sub_b(fix_val);
                state_d             = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            b_zero_q  <= 1'b0;
            dvd_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result_o  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (div_valid_i) begin
                        op_q      <= div_op_i;
                        dvd_q     <= div_a_i;
                        divisor_q <= div_b_i;
                        rem_q     <= '0;
                        sa_q      <= ~div_op_i[0] & div_a_i[31];
                        sb_q      <= ~div_op_i[0] & div_b_i[31];
                        b_zero_q  <= (div_b_i == 32'h0);
                    end
                end
                ABS_A: begin
                    if (sa_q) dvd_q <= adder_sum;
                end
                ABS_B: begin
                    if (sb_q) divisor_q <= adder_sum;
                    cnt_q <= 5'd31;
                    // Shortcut lands on the same answer the 32 iterations would produce.
                    if (FAST_DIV0 && b_zero_q) begin
                        rem_q <= dvd_q;
                        dvd_q <= '1;
                    end
                end
                DIV: begin
                    rem_q <= take ? adder_sum : shifted;
                    dvd_q <= {dvd_q[30:0], take};
                    cnt_q <= cnt_q - 5'd1;
                end
                FIX: begin
                    if (!kill_i) result_o <= fix_neg ? adder_sum : fix_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_div_seq.sv
// Randomized and directed bench for ibex_div_seq against an arithmetic reference,
// with a second instance built with FAST_DIV0=1.
module tb_ibex_div_seq;
    import ibex_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid, kill, ready, en, rv, busy;
    logic [1:0]  op;
    logic [31:0] a, b, res;
    logic [32:0] opa, opb;
    logic [33:0] adder;

    logic        f_valid, f_kill, f_ready, f_en, f_rv, f_busy;
    logic [1:0]  f_op;
    logic [31:0] f_a, f_b, f_res;
    logic [32:0] f_opa, f_opb;
    logic [33:0] f_adder;

    // Stand-in for the ALU's shared adder.
    assign adder   = {1'b0, opa} + {1'b0, opb};
    assign f_adder = {1'b0, f_opa} + {1'b0, f_opb};

    ibex_div_seq #(.FAST_DIV0(1'b0)) u_dut (
        .clk_i(clk), .rst_i(rst), .div_valid_i(valid), .div_ready_o(ready),
        .div_op_i(op), .div_a_i(a), .div_b_i(b), .kill_i(kill),
        .multdiv_en_o(en), .multdiv_operand_a_o(opa), .multdiv_operand_b_o(opb),
        .adder_result_ext_i(adder), .result_o(res), .result_valid_o(rv), .busy_o(busy)
    );

    ibex_div_seq #(.FAST_DIV0(1'b1)) u_fast (
        .clk_i(clk), .rst_i(rst), .div_valid_i(f_valid), .div_ready_o(f_ready),
        .div_op_i(f_op), .div_a_i(f_a), .div_b_i(f_b), .kill_i(f_kill),
        .multdiv_en_o(f_en), .multdiv_operand_a_o(f_opa), .multdiv_operand_b_o(f_opb),
        .adder_result_ext_i(f_adder), .result_o(f_res), .result_valid_o(f_rv), .busy_o(f_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] q, r;
        int sx, sy;
        if (y == 32'h0) begin
            q = 32'hFFFFFFFF;
            r = x;
        end else if (o == DIV_OP_DIV || o == DIV_OP_REM) begin
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                q = x;
                r = 32'h0;
            end else begin
                sx = x;
                sy = y;
                q  = sx / sy;
                r  = sx % sy;
            end
        end else begin
            q = x / y;
            r = x % y;
        end
        return (o == DIV_OP_REM || o == DIV_OP_REMU) ? r : q;
    endfunction

    task automatic start(input bit fast, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int guard = 0;
        @(negedge clk);
        while (!(fast ? f_ready : ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("ready_timeout", 32'd0, 32'd1);
        if (fast) begin
            f_valid = 1'b1; f_op = o; f_a = x; f_b = y;
        end else begin
            valid = 1'b1; op = o; a = x; b = y;
        end
        @(posedge clk);
        #1;
        valid   = 1'b0;
        f_valid = 1'b0;
    endtask

    // Latency counts rising edges with the accept edge as edge 1.
    task automatic wait_result(input bit fast, output logic [31:0] r, output int lat);
        lat = 0;
        r   = '0;
        for (int i = 2; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (fast ? f_rv : rv) begin
                lat = i;
                r   = fast ? f_res : res;
                break;
            end
        end
        if (lat == 0) chk("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_check(input bit fast, input string tag, input logic [1:0] o,
                             input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] exp, input int exp_lat);
        logic [31:0] r;
        int lat;
        start(fast, o, x, y);
        wait_result(fast, r, lat);
        chk({tag, "_res"}, r, exp);
        chk({tag, "_lat"}, lat, exp_lat);
        @(posedge clk);
        #1;
        chk({tag, "_pulse1"}, fast ? f_rv : rv, 1'b0);
    endtask

    initial begin
        logic [31:0] x, y;
        logic [1:0]  o;
        int lat, seen;

        rst = 1'b1; valid = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        f_valid = 1'b0; f_kill = 1'b0; f_op = '0; f_a = '0; f_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res", res, 32'h0);
        chk("rst_valid", rv, 1'b0);
        chk("rst_en", en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_ops", 32'(opa != 0 || opb != 0), 32'd0);
        rst = 1'b0;

        run_check(0, "divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 36);
        run_check(0, "remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 36);
        run_check(0, "div_m7_2",   DIV_OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 36);
        run_check(0, "rem_m7_2",   DIV_OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 36);
        run_check(0, "div_5_0",    DIV_OP_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 36);
        run_check(0, "rem_5_0",    DIV_OP_REM,  32'd5, 32'd0, 32'd5, 36);
        run_check(0, "div_m5_0",   DIV_OP_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 36);
        run_check(0, "rem_m5_0",   DIV_OP_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 36);
        run_check(0, "divu_5_0",   DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 36);
        run_check(0, "div_ovf",    DIV_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 36);
        run_check(0, "rem_ovf",    DIV_OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0, 36);

        run_check(1, "fast_div_5_0",  DIV_OP_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 4);
        run_check(1, "fast_rem_5_0",  DIV_OP_REM,  32'd5, 32'd0, 32'd5, 4);
        run_check(1, "fast_rem_m5_0", DIV_OP_REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 4);
        run_check(1, "fast_divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 36);

        // Kill in DIV iteration 10 (cycle 13 counting ABS_A as cycle 1).
        start(0, DIV_OP_DIVU, 32'd1000, 32'd3);
        repeat (12) @(posedge clk);
        #1;
        chk("kill_pre_en", en, 1'b1);
        chk("kill_pre_busy", busy, 1'b1);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_ready", ready, 1'b1);
        chk("kill_en", en, 1'b0);
        chk("kill_busy", busy, 1'b0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rv) seen++;
        end
        chk("kill_no_valid", seen, 0);
        run_check(0, "after_kill_divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 36);

        // Reset while in FIX (cycle 35).
        start(0, DIV_OP_DIVU, 32'd77, 32'd5);
        repeat (34) @(posedge clk);
        #1;
        chk("fix_en", en, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstfix_res", res, 32'h0);
        chk("rstfix_valid", rv, 1'b0);
        chk("rstfix_en", en, 1'b0);
        chk("rstfix_busy", busy, 1'b0);
        chk("rstfix_ops", 32'(opa != 0 || opb != 0), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstfix_no_valid", rv, 1'b0);

        // Back-to-back with valid held high.
        @(negedge clk);
        valid = 1'b1; op = DIV_OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        lat = 0;
        for (int i = 2; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (rv) begin lat = i; break; end
        end
        chk("b2b_lat1", lat, 36);
        chk("b2b_res1", res, 32'd14);
        chk("b2b_done_ready", ready, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_idle_ready", ready, 1'b1);
        chk("b2b_idle_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_accept", busy, 1'b1);
        lat = 0;
        for (int i = 2; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (rv) begin lat = i; break; end
        end
        valid = 1'b0;
        chk("b2b_lat2", lat, 36);
        chk("b2b_res2", res, 32'd14);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_idle_after", busy, 1'b0);

        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       x = 32'($urandom_range(0, 100));
                1:       x = 32'h80000000;
                2:       x = -32'($urandom_range(0, 100));
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       y = 32'h0;
                1:       y = 32'hFFFFFFFF;
                2:       y = 32'($urandom_range(1, 20));
                3:       y = -32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            run_check(0, "rnd", o, x, y, ref_div(o, x, y), 36);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ibex_div_seq.md
Name: ibex_div_seq

Overview:
- Iterative 32-bit integer divider sequencer for DIV, DIVU, REM and REMU.
- Has no adder of its own. It takes the ALU's shared 33-bit adder through the multdiv port (multdiv_en/operand_a/operand_b in, adder_result_ext back).
- Sits beside the ALU in the EX stage. While the sequence runs, it owns the adder and signals busy so the decoder stalls other ALU use.
- Fixed latency restoring division with sign pre- and post-processing.

Parameters:
- FAST_DIV0, 1'b0, when 1 a zero divisor skips the 32 iteration cycles and goes straight to FIX.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- div_valid_i  in  1  request valid
- div_ready_o  out  1  high only in IDLE
- div_op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- div_a_i  in  32  dividend, sampled on accept
- div_b_i  in  32  divisor, sampled on accept
- kill_i  in  1  abort the current operation (flush)
- multdiv_en_o  out  1  claims the ALU adder input mux
- multdiv_operand_a_o  out  33  ALU adder input A
- multdiv_operand_b_o  out  33  ALU adder input B
- adder_result_ext_i  in  34  ALU adder output; [32:1] is the sum, [33] is the carry-out
- result_o  out  32  registered quotient or remainder
- result_valid_o  out  1  one-cycle pulse
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Clocking and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: state=IDLE, result_o=0, result_valid_o=0, multdiv_en_o=0, busy_o=0, operand outputs=0. All internal registers are cleared.
- Accept: div_valid_i & div_ready_o at a rising edge.
  - Latch op, a, b.
  - signed = ~op[0]; sa = signed & a[31]; sb = signed & b[31].
  - b_zero = (b==0).
- States and transitions: IDLE -> ABS_A -> ABS_B -> DIV (32 cycles, counter 31..0) -> FIX -> DONE -> IDLE.
- Adder usage: multdiv_en_o=1 in ABS_A, ABS_B, DIV and FIX, and 0 otherwise.
- Negate x: drive A = {32'h0,1'b1}, B = {~x,1'b1}; result = adder_result_ext_i[32:1] (equals -x).
  - ABS_A: if sa, dividend <= -a.
  - ABS_B: if sb, divisor <= -b.
  - When negation is not needed, the operand is held and the outputs are still driven, giving a deterministic cycle count.
- DIV iteration (restoring):
  - shifted = {rem[30:0], dvd[31]}.
  - Drive A = {shifted,1'b1}, B = {~divisor,1'b1}.
  - take = rem[31] | adder_result_ext_i[33].
  - rem <= take ? adder_result_ext_i[32:1] : shifted.
  - dvd <= {dvd[30:0], take}; the quotient accumulates in dvd.
- FIX:
  - DIV ops: negate the quotient iff (sa^sb) & ~b_zero.
  - REM ops: negate the remainder iff sa.
  - The negation uses the adder as above; the result is registered into result_o.
- DONE:
  - result_valid_o = 1 for exactly one cycle.
  - Next state is IDLE; a new request is accepted in the following cycle, not in DONE.
- Latency: result_valid_o rises 36 cycles after the accept edge (ABS_A at cycle 1 through DONE at cycle 36). With FAST_DIV0=1 and b_zero, it rises 4 cycles after accept.
- Divide by zero: quotient = 32'hFFFFFFFF and remainder = dividend, for both signed and unsigned ops. This falls out of the algorithm together with the b_zero guard.
- Overflow: 0x80000000 / -1 gives quotient 0x80000000 and remainder 0. The magnitude 2^31 is handled as unsigned.
- kill_i: in any non-IDLE state, next state is IDLE with no result_valid_o. kill_i in IDLE is ignored. kill_i in DONE suppresses nothing; the pulse is already out.
- rst_i mid-operation: IDLE at the next edge, all outputs at reset values.
- div_valid_i while busy: not accepted; the request must be held until ready.

Decomposition:
- Shared package (ibex_pkg) holds:
  - the div_op encoding constants (DIV_OP_DIV/DIVU/REM/REMU);
  - the div_state enum (IDLE, ABS_A, ABS_B, DIV, FIX, DONE).
- No sub-module: the negate/subtract operand formatting is two small functions local to the block.

Test Plan:
- DIVU a=100, b=7 -> result_o=14 with result_valid_o exactly 36 cycles after accept; REMU same operands -> 2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV -5/0 -> 0xFFFFFFFF. With FAST_DIV0=1, latency is 4 cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- kill_i at DIV iteration 10 -> no valid pulse; back in IDLE next cycle (ready=1, multdiv_en_o=0). A following DIVU 9/3 -> 3.
- rst_i asserted in FIX -> all outputs 0 next cycle. Back-to-back requests with valid held high -> second accepted the cycle after DONE.
